vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_if.sv | 33 +++
 rtl/vga_timing_gen.sv | 118 +++++++++++
 tb/tb_vga_timing_gen.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster bus between the VGA timing generator and its consumers.
// The master modport is the timing generator; the slave modport is a pixel or sync consumer.
interface vga_timing_gen_if #(
    parameter int CW = 10,
    parameter int FW = 8
);
    logic          i_Enable;
    logic          o_Pix_En;
    logic [CW-1:0] o_Column;
    logic [CW-1:0] o_Row;
    logic          o_Active;
    logic          o_Line_Start;
    logic          o_Frame_Start;
    logic          o_VBlank_Start;
    logic [FW-1:0] o_Frame_Count;
    logic          o_HSync;
    logic          o_VSync;
    logic          o_Active_D;

    modport master (
        input  i_Enable,
        output o_Pix_En, o_Column, o_Row, o_Active,
        output o_Line_Start, o_Frame_Start, o_VBlank_Start, o_Frame_Count,
        output o_HSync, o_VSync, o_Active_D
    );

    modport slave (
        output i_Enable,
        input  o_Pix_En, o_Column, o_Row, o_Active,
        input  o_Line_Start, o_Frame_Start, o_VBlank_Start, o_Frame_Count,
        input  o_HSync, o_VSync, o_Active_D
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: pixel-tick divider, column/row/frame counters,
// sync/active decode with a DELAY-stage alignment pipeline and one-tick strobes.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FPORCH = 16,
    parameter int unsigned H_PULSE  = 96,
    parameter int unsigned H_BPORCH = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FPORCH = 10,
    parameter int unsigned V_PULSE  = 2,
    parameter int unsigned V_BPORCH = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned CLK_DIV  = 1,
    parameter int unsigned DELAY    = 1,
    parameter int unsigned CW       = 10,
    parameter int unsigned FW       = 8
) (
    input  logic          i_Clk,
    input  logic          i_Rst_L,
    vga_timing_gen_if.master bus
);
    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FPORCH + H_PULSE + H_BPORCH;
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FPORCH + V_PULSE + V_BPORCH;
    localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FPORCH;
    localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_PULSE;
    localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FPORCH;
    localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_PULSE;
    localparam int unsigned DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(V_TOTAL - 1);

    logic [DW-1:0]            r_div;
    logic [CW-1:0]            r_col;
    logic [CW-1:0]            r_row;
    logic [FW-1:0]            r_frame;
    logic [DELAY-1:0][2:0]    r_dly;
    logic [DELAY-1:0][2:0]    w_stage_in;

    logic w_pix_en;
    logic w_col_last;
    logic w_row_last;
    logic w_col_zero;
    logic w_hs;
    logic w_vs;
    logic w_act;

    assign w_pix_en   = bus.i_Enable && (r_div == DIV_LAST);
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_col_zero = (r_col == '0);

    assign w_hs  = (r_col >= CW'(H_SYNC_BEG)) && (r_col < CW'(H_SYNC_END));
    assign w_vs  = (r_row >= CW'(V_SYNC_BEG)) && (r_row < CW'(V_SYNC_END));
    assign w_act = (r_col < CW'(H_ACTIVE)) && (r_row < CW'(V_ACTIVE));

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_div <= '0;
        end else if (bus.i_Enable) begin
            r_div <= w_pix_en ? '0 : r_div + 1'b1;
        end
    end

    // Row and frame count only move on the tick that wraps the column.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_col   <= '0;
            r_row   <= '0;
            r_frame <= '0;
        end else if (w_pix_en) begin
            if (w_col_last) begin
                r_col <= '0;
                if (w_row_last) begin
                    r_row   <= '0;
                    r_frame <= r_frame + 1'b1;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Stage inputs for the {hsync, vsync, active} pipeline; stage 0 takes the live decode.
    generate
        for (genvar gi = 0; gi < DELAY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_stage_in[gi] = {w_hs, w_vs, w_act};
            end else begin : g_tail
                assign w_stage_in[gi] = r_dly[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_dly <= '0;
        end else if (w_pix_en) begin
            r_dly <= w_stage_in;
        end
    end

    assign bus.o_Pix_En       = w_pix_en;
    assign bus.o_Column       = r_col;
    assign bus.o_Row          = r_row;
    assign bus.o_Active       = w_act;
    assign bus.o_Frame_Count  = r_frame;
    assign bus.o_Line_Start   = w_pix_en && w_col_zero;
    assign bus.o_Frame_Start  = w_pix_en && w_col_zero && (r_row == '0);
    assign bus.o_VBlank_Start = w_pix_en && w_col_zero && (r_row == CW'(V_ACTIVE));
    assign bus.o_HSync        = r_dly[DELAY-1][2] ? H_POL : ~H_POL;
    assign bus.o_VSync        = r_dly[DELAY-1][1] ? V_POL : ~V_POL;
    assign bus.o_Active_D     = r_dly[DELAY-1][0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing, divided/inverted/delayed
// variant, and a tiny raster with a 2-bit frame counter.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;

    vga_timing_gen_if #(.CW(10), .FW(8)) if0 ();
    vga_timing_gen_if #(.CW(10), .FW(8)) if1 ();
    vga_timing_gen_if #(.CW(5),  .FW(2)) if2 ();

    vga_timing_gen u0 (.i_Clk(clk), .i_Rst_L(rst0), .bus(if0));

    vga_timing_gen #(
        .CLK_DIV(4), .DELAY(3), .H_POL(1'b1), .V_POL(1'b1)
    ) u1 (.i_Clk(clk), .i_Rst_L(rst1), .bus(if1));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FPORCH(2), .H_PULSE(2), .H_BPORCH(2),
        .V_ACTIVE(4), .V_FPORCH(1), .V_PULSE(1), .V_BPORCH(1),
        .CW(5), .FW(2)
    ) u2 (.i_Clk(clk), .i_Rst_L(rst2), .bus(if2));

    int n_cmp = 0;
    int n_bad = 0;

    int n, bad, ln;
    int lo_cnt [2];
    int lo_first [2];
    int act_cnt [2];
    int actd_cnt [2];
    int ls_cnt, fs_cnt;
    logic hs, vs, ad;
    logic [7:0] fc;
    int pe_cnt, pe_bad, c656, ad_first, rise1, rise2, fall1;
    logic prev;
    int fs_idx, fs_last, per_bad, vb_cnt, vb_first, vb_bad, vs_lo, vs_first, ad2_cnt, fs_bad;
    int exp_fc [6] = '{0, 1, 2, 3, 0, 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        if ((800 >= 2**10) || (525 >= 2**10) || (14 >= 2**5) || (7 >= 2**5)) begin
            $display("FAIL elab: raster totals do not fit in CW");
            $fatal(1);
        end

        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        if0.i_Enable = 1'b0; if1.i_Enable = 1'b0; if2.i_Enable = 1'b0;
        #2;
        // Reset state, enable low
        check("rst_col",    32'(if0.o_Column), 0);
        check("rst_row",    32'(if0.o_Row), 0);
        check("rst_frame",  32'(if0.o_Frame_Count), 0);
        check("rst_hs",     32'(if0.o_HSync), 1);
        check("rst_vs",     32'(if0.o_VSync), 1);
        check("rst_actd",   32'(if0.o_Active_D), 0);
        check("rst_pix_en", 32'(if0.o_Pix_En), 0);
        check("rst_ls_off", 32'(if0.o_Line_Start), 0);
        check("rst_hs_pol1", 32'(if1.o_HSync), 0);
        check("rst_vs_pol1", 32'(if1.o_VSync), 0);

        // Enable while still in reset: strobes only for CLK_DIV=1
        if0.i_Enable = 1'b1; if1.i_Enable = 1'b1; if2.i_Enable = 1'b1;
        #1;
        check("rst_en_pix",   32'(if0.o_Pix_En), 1);
        check("rst_en_fs",    32'(if0.o_Frame_Start), 1);
        check("rst_en_ls",    32'(if0.o_Line_Start), 1);
        check("rst_en_pix_d4", 32'(if1.o_Pix_En), 0);
        check("rst_en_fs_sm", 32'(if2.o_Frame_Start), 1);
        check("rst_en_vb_sm", 32'(if2.o_VBlank_Start), 0);
        tick();
        check("rst_hold_col", 32'(if0.o_Column), 0);

        // Default timing: two full lines
        rst0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            lo_cnt[i] = 0; lo_first[i] = -1; act_cnt[i] = 0; actd_cnt[i] = 0;
        end
        ls_cnt = 0; fs_cnt = 0;
        for (int s = 0; s < 1600; s++) begin
            ln = s / 800;
            if (if0.o_HSync === 1'b0) begin
                if (lo_first[ln] < 0) lo_first[ln] = s;
                lo_cnt[ln]++;
            end
            if (if0.o_Active_D) actd_cnt[ln]++;
            if (if0.o_Active) act_cnt[ln]++;
            ls_cnt += int'(if0.o_Line_Start);
            fs_cnt += int'(if0.o_Frame_Start);
            tick();
        end
        check("l0_hs_first", 32'(lo_first[0]), 657);
        check("l0_hs_width", 32'(lo_cnt[0]), 96);
        check("l1_hs_first", 32'(lo_first[1]), 1457);
        check("l1_hs_width", 32'(lo_cnt[1]), 96);
        check("l0_active",   32'(act_cnt[0]), 640);
        check("l0_active_d", 32'(actd_cnt[0]), 640);
        check("l1_active_d", 32'(actd_cnt[1]), 640);
        check("line_starts", 32'(ls_cnt), 2);
        check("frame_starts", 32'(fs_cnt), 1);
        check("after2_col",  32'(if0.o_Column), 0);
        check("after2_row",  32'(if0.o_Row), 2);

        // Freeze at column 300, row 10
        n = 0;
        while (!(if0.o_Column == 300 && if0.o_Row == 10) && n < 10000) begin
            tick();
            n++;
        end
        check("to_freeze_ticks", 32'(n), 6700);
        if0.i_Enable = 1'b0;
        #1;
        hs = if0.o_HSync; vs = if0.o_VSync; ad = if0.o_Active_D; fc = if0.o_Frame_Count;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (if0.o_Column != 300 || if0.o_Row != 10 || if0.o_Pix_En !== 1'b0 ||
                if0.o_Line_Start !== 1'b0 || if0.o_Frame_Start !== 1'b0 ||
                if0.o_VBlank_Start !== 1'b0 || if0.o_HSync !== hs ||
                if0.o_VSync !== vs || if0.o_Active_D !== ad || if0.o_Frame_Count !== fc)
                bad++;
            tick();
        end
        check("freeze_hold", 32'(bad), 0);
        check("freeze_actd", 32'(ad), 1);
        check("freeze_hs",   32'(hs), 1);
        if0.i_Enable = 1'b1;
        tick();
        check("resume_col", 32'(if0.o_Column), 301);
        check("resume_row", 32'(if0.o_Row), 10);

        // Async reset inside the hsync pulse
        n = 0;
        while (if0.o_Column != 700 && n < 1000) begin
            tick();
            n++;
        end
        check("to_700_ticks", 32'(n), 399);
        check("hs_at_700", 32'(if0.o_HSync), 0);
        #3;
        rst0 = 1'b0;
        #1;
        check("arst_hs",    32'(if0.o_HSync), 1);
        check("arst_col",   32'(if0.o_Column), 0);
        check("arst_row",   32'(if0.o_Row), 0);
        check("arst_actd",  32'(if0.o_Active_D), 0);
        tick();
        check("arst_hold_col", 32'(if0.o_Column), 0);
        rst0 = 1'b1;
        lo_cnt[0] = 0; lo_first[0] = -1;
        for (int s = 0; s <= 700; s++) begin
            if (if0.o_HSync === 1'b0) begin
                if (lo_first[0] < 0) lo_first[0] = s;
                lo_cnt[0]++;
            end
            tick();
        end
        check("arst_hs_first", 32'(lo_first[0]), 657);
        check("arst_hs_lows",  32'(lo_cnt[0]), 44);

        // CLK_DIV=4, DELAY=3, active-high syncs
        rst1 = 1'b1;
        pe_cnt = 0; pe_bad = 0; c656 = -1; ad_first = -1; rise1 = -1; rise2 = -1; fall1 = -1;
        prev = if1.o_HSync;
        for (int s = 0; s < 6000; s++) begin
            if (if1.o_Pix_En) begin
                pe_cnt++;
                if (s % 4 != 3) pe_bad++;
            end
            if (c656 < 0 && if1.o_Column == 656) c656 = s;
            if (ad_first < 0 && if1.o_Active_D === 1'b1) ad_first = s;
            if (if1.o_HSync === 1'b1 && prev === 1'b0) begin
                if (rise1 < 0) rise1 = s;
                else if (rise2 < 0) rise2 = s;
            end
            if (if1.o_HSync === 1'b0 && prev === 1'b1 && rise1 >= 0 && fall1 < 0) fall1 = s;
            prev = if1.o_HSync;
            tick();
        end
        check("d4_pix_cnt",   32'(pe_cnt), 1500);
        check("d4_pix_phase", 32'(pe_bad), 0);
        check("d4_col656",    32'(c656), 2624);
        check("d4_hs_rise",   32'(rise1), 2636);
        check("d4_hs_width",  32'(fall1 - rise1), 384);
        check("d4_line_per",  32'(rise2 - rise1), 3200);
        check("d4_actd_lat",  32'(ad_first), 12);

        // Small raster, 2-bit frame counter, five frames
        rst2 = 1'b1;
        fs_idx = 0; fs_last = -1; per_bad = 0; fs_bad = 0; vb_cnt = 0; vb_first = -1; vb_bad = 0;
        vs_lo = 0; vs_first = -1; ad2_cnt = 0;
        for (int s = 0; s <= 490; s++) begin
            if (if2.o_Frame_Start) begin
                if (fs_idx < 6) check("sm_frame_count", 32'(if2.o_Frame_Count), 32'(exp_fc[fs_idx]));
                if (if2.o_Column != 0 || if2.o_Row != 0 || if2.o_Line_Start !== 1'b1) fs_bad++;
                if (fs_last >= 0 && s - fs_last != 98) per_bad++;
                fs_last = s;
                fs_idx++;
            end
            if (if2.o_VBlank_Start) begin
                if (vb_first < 0) vb_first = s;
                vb_cnt++;
                if (if2.o_Column != 0 || if2.o_Row != 4 || if2.o_Line_Start !== 1'b1) vb_bad++;
            end
            if (if2.o_VSync === 1'b0) begin
                if (vs_first < 0) vs_first = s;
                vs_lo++;
            end
            if (if2.o_Active_D) ad2_cnt++;
            tick();
        end
        check("sm_fs_count",  32'(fs_idx), 6);
        check("sm_fs_at_00",  32'(fs_bad), 0);
        check("sm_period",    32'(per_bad), 0);
        check("sm_vb_count",  32'(vb_cnt), 5);
        check("sm_vb_first",  32'(vb_first), 56);
        check("sm_vb_pos",    32'(vb_bad), 0);
        check("sm_vs_lows",   32'(vs_lo), 70);
        check("sm_vs_first",  32'(vs_first), 71);
        check("sm_active_d",  32'(ad2_cnt), 160);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
